// File: rtl/mulseq_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
// Sizing functions are evaluated at elaboration time by mulseq.
package mulseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cdiv(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mulseq_pp.sv
// Combinational partial product: unsigned magnitude times a DIGIT-bit slice.
// Result width WIDTH+DIGIT always holds mag * (2^DIGIT - 1).
module mulseq_pp #(
  parameter int WIDTH = 11,
  parameter int DIGIT = 1
) (
  input  logic [WIDTH-1:0]       mag,
  input  logic [DIGIT-1:0]       dig,
  output logic [WIDTH+DIGIT-1:0] pp
);

  localparam int PW = WIDTH + DIGIT;

  always_comb begin
    pp = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (dig[i]) begin
        pp = pp + (PW'(mag) << i);
      end
    end
  end

endmodule

// File: rtl/mulseq.sv
// Iterative WIDTHxWIDTH multiplier, DIGIT multiplier bits per cycle,
// valid/ready on both sides, unsigned or signed per operation.
module mulseq
  import mulseq_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DIGIT = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int N  = cdiv(WIDTH, DIGIT);
  localparam int NB = N * DIGIT;
  localparam int CW = cnt_width(N);
  localparam int PW = WIDTH + DIGIT;
  localparam int AW = 2 * WIDTH + DIGIT;
  localparam int RW = 2 * WIDTH;

  state_e st_q, st_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] p_q, p_d;
  logic [WIDTH-1:0] am_q, am_d;
  logic [NB-1:0] bs_q, bs_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    pp;
  logic [CW-1:0]    step;
  logic [31:0]      sh;
  logic [AW-1:0]    pp_ext;
  logic [AW-1:0]    acc_sum;
  logic [RW-1:0]    prod;

  mulseq_pp #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) u_pp (
    .mag(am_q),
    .dig(bs_q[DIGIT-1:0]),
    .pp (pp)
  );

  // Iteration index counts up while cnt_q counts down to zero.
  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    step    = CW'(N - 1) - cnt_q;
    sh      = 32'(step) * DIGIT;
    pp_ext  = AW'(pp) << sh;
    acc_sum = acc_q + pp_ext;
    prod    = acc_sum[RW-1:0];
  end

  always_comb begin
    st_d        = st_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    am_d        = am_q;
    bs_d        = bs_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    unique case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d       = ST_BUSY;
          in_ready_d = 1'b0;
          am_d       = a_mag;
          bs_d       = NB'(b_mag);
          neg_d      = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d      = '0;
          cnt_d      = CW'(N - 1);
        end
      end
      ST_BUSY: begin
        acc_d = acc_sum;
        bs_d  = bs_q >> DIGIT;
        if (cnt_q == '0) begin
          st_d        = ST_DONE;
          out_valid_d = 1'b1;
          p_d         = neg_q ? -prod : prod;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          st_d        = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        st_d        = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      am_q        <= '0;
      bs_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      am_q        <= am_d;
      bs_q        <= bs_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_mulseq.sv
// Bench for mulseq: seven parameterisations driven in lockstep,
// directed table, backpressure, reset and exhaustive/random sweeps.
module tb_mulseq;

  localparam int NI = 7;
  localparam int CFG_W [NI] = '{11, 11, 11, 11, 4, 4, 4};
  localparam int CFG_D [NI] = '{1, 2, 3, 11, 1, 3, 4};
  localparam int CFG_N [NI] = '{11, 6, 4, 1, 4, 2, 1};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        is_s = 1'b0;
  logic [10:0] a_in = '0;
  logic [10:0] b_in = '0;

  logic        ir_a [NI];
  logic        ov_a [NI];
  logic [63:0] p_a  [NI];

  int npass = 0;
  int ntot  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = CFG_W[g];
    localparam int D = CFG_D[g];
    logic           ir;
    logic           ov;
    logic [2*W-1:0] pw;
    mulseq #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (ir),
      .a        (a_in[W-1:0]),
      .b        (b_in[W-1:0]),
      .is_signed(is_s),
      .out_valid(ov),
      .out_ready(out_ready),
      .p        (pw)
    );
    assign ir_a[g] = ir;
    assign ov_a[g] = ov;
    assign p_a[g]  = 64'(pw);
  end

  typedef struct {
    logic [10:0] a;
    logic [10:0] b;
    bit          s;
    logic [21:0] p;
  } vec_t;

  vec_t tv [9];

  function automatic logic [63:0] ref_mul(input int w, input logic [10:0] a,
                                          input logic [10:0] b, input bit s);
    longint m;
    longint av;
    longint bv;
    longint pr;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (s && av[w-1]) av = av - (longint'(1) << w);
    if (s && bv[w-1]) bv = bv - (longint'(1) << w);
    pr = av * bv;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_op(input logic [10:0] a, input logic [10:0] b, input bit s,
                        input bit noisy, input int hold,
                        input bit has_exp, input logic [21:0] exp11);
    int  lat [NI];
    bit  all;
    @(negedge clock);
    for (int i = 0; i < NI; i++) chk($sformatf("idle_rdy[%0d]", i), 64'(ir_a[i]), 64'd1);
    a_in = a; b_in = b; is_s = s; in_valid = 1'b1;
    @(posedge clock); #1;
    if (!noisy) in_valid = 1'b0;
    for (int i = 0; i < NI; i++) lat[i] = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      all = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (ov_a[i] && lat[i] < 0) lat[i] = c;
        if (lat[i] < 0) all = 1'b0;
      end
      if (noisy) begin
        a_in = 11'($urandom); b_in = 11'($urandom); is_s = 1'($urandom);
      end
      if (all) break;
    end
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("lat[%0d]", i), 64'(lat[i]), 64'(CFG_N[i]));
      chk($sformatf("p[%0d] a=%0h b=%0h s=%0d", i, a, b, s), p_a[i],
          ref_mul(CFG_W[i], a, b, s));
      if (has_exp && CFG_W[i] == 11)
        chk($sformatf("p_dir[%0d]", i), p_a[i], 64'(exp11));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("hold_ov[%0d]", i), 64'(ov_a[i]), 64'd1);
        chk($sformatf("hold_rdy[%0d]", i), 64'(ir_a[i]), 64'd0);
        chk($sformatf("hold_p[%0d]", i), p_a[i], ref_mul(CFG_W[i], a, b, s));
      end
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("post_rdy[%0d]", i), 64'(ir_a[i]), 64'd1);
      chk($sformatf("post_ov[%0d]", i), 64'(ov_a[i]), 64'd0);
    end
  endtask

  initial begin
    logic [10:0] ra;
    logic [10:0] rb;
    int          ov_seen;

    tv[0] = '{11'h7FF, 11'h7FF, 1'b0, 22'd4190209};
    tv[1] = '{11'h400, 11'h400, 1'b1, 22'h100000};
    tv[2] = '{11'h7FF, 11'h005, 1'b1, 22'h3FFFFB};
    tv[3] = '{11'h000, 11'h7FF, 1'b0, 22'h000000};
    tv[4] = '{11'h3FF, 11'h3FF, 1'b1, 22'h0FF801};
    tv[5] = '{11'h400, 11'h3FF, 1'b1, 22'h300400};
    tv[6] = '{11'h400, 11'h003, 1'b0, 22'h000C00};
    tv[7] = '{11'h001, 11'h7FF, 1'b1, 22'h3FFFFF};
    tv[8] = '{11'd123, 11'd45,  1'b0, 22'h00159F};

    #12;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_rdy[%0d]", i), 64'(ir_a[i]), 64'd1);
      chk($sformatf("rst_ov[%0d]", i), 64'(ov_a[i]), 64'd0);
      chk($sformatf("rst_p[%0d]", i), p_a[i], 64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 9; k++)
      run_op(tv[k].a, tv[k].b, tv[k].s, 1'b0, 0, 1'b1, tv[k].p);

    run_op(11'h7FF, 11'h7FF, 1'b0, 1'b0, 10, 1'b1, 22'd4190209);
    run_op(11'h7FF, 11'h005, 1'b1, 1'b1, 0, 1'b1, 22'h3FFFFB);
    run_op(11'h400, 11'h3FF, 1'b1, 1'b1, 2, 1'b1, 22'h300400);

    // Reset pulled while the slowest instance is mid-iteration.
    @(negedge clock);
    a_in = 11'h123; b_in = 11'h456; is_s = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_rst_rdy[%0d]", i), 64'(ir_a[i]), 64'd1);
      chk($sformatf("mid_rst_ov[%0d]", i), 64'(ov_a[i]), 64'd0);
      chk($sformatf("mid_rst_p[%0d]", i), p_a[i], 64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    ov_seen = 0;
    repeat (20) begin
      @(posedge clock); #1;
      for (int i = 0; i < NI; i++) if (ov_a[i]) ov_seen++;
    end
    chk("no_ov_after_rst", 64'(ov_seen), 64'd0);
    run_op(11'h7FF, 11'h7FF, 1'b0, 1'b0, 0, 1'b1, 22'd4190209);

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          ra = 11'($urandom); rb = 11'($urandom);
          ra[3:0] = 4'(x); rb[3:0] = 4'(y);
          run_op(ra, rb, 1'(s), 1'b0, 0, 1'b0, 22'd0);
        end

    for (int k = 0; k < 60; k++)
      run_op(11'($urandom), 11'($urandom), 1'(k & 1), 1'b0, 0, 1'b0, 22'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
